// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and helpers shared by the video timing blocks.
package vga_timing_pkg;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   function automatic int unsigned timing_total(input int unsigned active, fp, sync_w, bp);
      return active + fp + sync_w + bp;
   endfunction

   function automatic int unsigned sync_first(input int unsigned active, fp);
      return active + fp;
   endfunction

   function automatic int unsigned sync_last(input int unsigned active, fp, sync_w);
      return active + fp + sync_w - 1;
   endfunction

   localparam int unsigned DEF_H_TOTAL  = timing_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int unsigned DEF_V_TOTAL  = timing_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
   localparam int unsigned DEF_HS_FIRST = sync_first(DEF_H_ACTIVE, DEF_H_FP);
   localparam int unsigned DEF_HS_LAST  = sync_last(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC);
   localparam int unsigned DEF_VS_FIRST = sync_first(DEF_V_ACTIVE, DEF_V_FP);
   localparam int unsigned DEF_VS_LAST  = sync_last(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single level signal, asynchronously cleared.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Video timing generator: lock-gated counters, a registered fetch stage and a
// LOOKAHEAD-deep delay to the display-aligned sync/de/x/y outputs.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
   parameter int unsigned H_FP      = DEF_H_FP,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BP      = DEF_H_BP,
   parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
   parameter int unsigned V_FP      = DEF_V_FP,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BP      = DEF_V_BP,
   parameter bit          HS_POL    = 1'b0,
   parameter bit          VS_POL    = 1'b0,
   parameter int unsigned LOOKAHEAD = 2,
   parameter int unsigned X_W       = 10,
   parameter int unsigned Y_W       = 10
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           pll_locked,
   output logic           running,
   output logic           fetch_valid,
   output logic [X_W-1:0] fetch_x,
   output logic [Y_W-1:0] fetch_y,
   output logic           frame_start,
   output logic           line_start,
   output logic           hsync,
   output logic           vsync,
   output logic           de,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y
);

   localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
   localparam logic [X_W-1:0] H_ACT_X  = X_W'(H_ACTIVE);
   localparam logic [X_W-1:0] HS_FIRST = X_W'(sync_first(H_ACTIVE, H_FP));
   localparam logic [X_W-1:0] HS_LAST  = X_W'(sync_last(H_ACTIVE, H_FP, H_SYNC));
   localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
   localparam logic [Y_W-1:0] V_ACT_Y  = Y_W'(V_ACTIVE);
   localparam logic [Y_W-1:0] VS_FIRST = Y_W'(sync_first(V_ACTIVE, V_FP));
   localparam logic [Y_W-1:0] VS_LAST  = Y_W'(sync_last(V_ACTIVE, V_FP, V_SYNC));

   if (X_W > 31 || H_TOTAL > (32'd1 << X_W)) begin : g_bad_x_w
      $error("X_W cannot hold H_TOTAL-1");
   end
   if (Y_W > 31 || V_TOTAL > (32'd1 << Y_W)) begin : g_bad_y_w
      $error("Y_W cannot hold V_TOTAL-1");
   end
   if (LOOKAHEAD < 1 || LOOKAHEAD > 8) begin : g_bad_lookahead
      $error("LOOKAHEAD must be in 1..8");
   end

   logic           lock_s;
   logic [X_W-1:0] hc;
   logic [Y_W-1:0] vc;
   logic           act_c, hs_c, vs_c;
   logic           f_hs, f_vs;

   logic           p_de [LOOKAHEAD];
   logic           p_hs [LOOKAHEAD];
   logic           p_vs [LOOKAHEAD];
   logic [X_W-1:0] p_x  [LOOKAHEAD];
   logic [Y_W-1:0] p_y  [LOOKAHEAD];

   sync_2ff u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lock_s)
   );

   assign running = lock_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hc <= '0;
         vc <= '0;
      end else if (!lock_s) begin
         hc <= '0;
         vc <= '0;
      end else if (hc == H_LAST) begin
         hc <= '0;
         vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
      end else begin
         hc <= hc + 1'b1;
      end
   end

   assign act_c = (hc < H_ACT_X) && (vc < V_ACT_Y);
   assign hs_c  = (hc >= HS_FIRST) && (hc <= HS_LAST);
   assign vs_c  = (vc >= VS_FIRST) && (vc <= VS_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_valid <= 1'b0;
         fetch_x     <= '0;
         fetch_y     <= '0;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
         f_hs        <= 1'b0;
         f_vs        <= 1'b0;
      end else if (!lock_s) begin
         fetch_valid <= 1'b0;
         fetch_x     <= '0;
         fetch_y     <= '0;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
         f_hs        <= 1'b0;
         f_vs        <= 1'b0;
      end else begin
         fetch_valid <= act_c;
         fetch_x     <= hc;
         fetch_y     <= vc;
         frame_start <= (hc == '0) && (vc == '0);
         line_start  <= (hc == '0) && (vc < V_ACT_Y);
         f_hs        <= hs_c;
         f_vs        <= vs_c;
      end
   end

   // Losing lock flushes every stage at once so no stale sync pulse drains out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < LOOKAHEAD; i++) begin
            p_de[i] <= 1'b0;
            p_hs[i] <= 1'b0;
            p_vs[i] <= 1'b0;
            p_x[i]  <= '0;
            p_y[i]  <= '0;
         end
      end else if (!lock_s) begin
         for (int unsigned i = 0; i < LOOKAHEAD; i++) begin
            p_de[i] <= 1'b0;
            p_hs[i] <= 1'b0;
            p_vs[i] <= 1'b0;
            p_x[i]  <= '0;
            p_y[i]  <= '0;
         end
      end else begin
         p_de[0] <= fetch_valid;
         p_hs[0] <= f_hs;
         p_vs[0] <= f_vs;
         p_x[0]  <= fetch_x;
         p_y[0]  <= fetch_y;
         for (int unsigned i = 1; i < LOOKAHEAD; i++) begin
            p_de[i] <= p_de[i-1];
            p_hs[i] <= p_hs[i-1];
            p_vs[i] <= p_vs[i-1];
            p_x[i]  <= p_x[i-1];
            p_y[i]  <= p_y[i-1];
         end
      end
   end

   assign de    = p_de[LOOKAHEAD-1];
   assign x     = p_x[LOOKAHEAD-1];
   assign y     = p_y[LOOKAHEAD-1];
   assign hsync = p_hs[LOOKAHEAD-1] ^ ~HS_POL;
   assign vsync = p_vs[LOOKAHEAD-1] ^ ~VS_POL;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Video timing generator clocked by the 25.2 MHz pixel clock from the PLL (outclk_1). It takes the PLL lock indication and holds video idle until lock is stable. It then produces 640x480@60 sync, data-enable and pixel coordinates. A look-ahead fetch coordinate leads the display timing by LOOKAHEAD cycles, so the downstream frame-buffer/memory read path has time to return pixel data.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
LOOKAHEAD, 2, cycles by which fetch_* leads display outputs; legal range 1..8
X_W, 10, coordinate width x
Y_W, 10, coordinate width y

Ports:
clk  in  1  pixel clock (PLL outclk_1, 25.2 MHz)
rst  in  1  asynchronous, active-high reset
pll_locked  in  1  PLL locked; asynchronous to clk
running  out  1  timing active (synchronized lock)
fetch_valid  out  1  fetch coordinate is in the active area
fetch_x  out  X_W  fetch column
fetch_y  out  Y_W  fetch row
frame_start  out  1  one-cycle pulse with fetch of (0,0)
line_start  out  1  one-cycle pulse with fetch of (0,y), every y < V_ACTIVE
hsync  out  1  display-aligned horizontal sync
vsync  out  1  display-aligned vertical sync
de  out  1  display data enable
x  out  X_W  display column (valid when de)
y  out  Y_W  display row (valid when de)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Frame = 420000 cycles.
- pll_locked passes through a 2-flop synchronizer to give lock_s. running = lock_s.
- Reset (async): all flops clear. running=0, fetch_valid=0, frame_start=0, line_start=0, de=0, x=y=fetch_x=fetch_y=0. hsync=~HS_POL and vsync=~VS_POL (inactive levels). The pipeline is cleared.
- Counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1):
  - Both are held at 0 while lock_s=0.
  - When lock_s=1, hc increments each cycle. At H_TOTAL-1, hc wraps to 0 and vc increments.
  - vc wraps at V_TOTAL-1 on the same edge that hc wraps.
- Line layout: active 0..H_ACTIVE-1, then front porch, sync, back porch. hsync is active for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = 656..751.
- Frame layout: vsync is active for whole lines vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = 490..491.
- Fetch stage (registered, 1-cycle latency from counters):
  - fetch_valid = (hc<H_ACTIVE)&&(vc<V_ACTIVE); fetch_x=hc, fetch_y=vc.
  - frame_start = (hc==0&&vc==0); line_start = (hc==0&&vc<V_ACTIVE).
  - fetch_x and fetch_y hold their last value when fetch_valid=0 is not required; they track the counters.
- Display stage: the fetch-stage values of valid, x, y, the hsync condition and the vsync condition pass through a LOOKAHEAD-deep shift pipeline.
  - de/x/y/hsync/vsync for a pixel appear exactly LOOKAHEAD cycles after the fetch outputs for the same pixel.
  - Sync levels are applied per HS_POL/VS_POL at the pipeline output.
- Start-up: at the first edge where lock_s=1, the counters are at (0,0). On the next edge fetch_valid=1, fetch_x=0, fetch_y=0 and frame_start=1. de=1 with x=0, y=0 follows LOOKAHEAD edges after that.
- Loss of lock (lock_s 1->0), at any point in the frame:
  - On the next edge the counters reset to 0, all pipeline stages clear to the inactive/zero values, and running=0.
  - No partial sync pulse is held; de/hsync/vsync go inactive at once, not LOOKAHEAD later.
  - On relock, start-up repeats from (0,0).
- pll_locked glitches shorter than one clk period may or may not be captured. Once a glitch is captured, it follows the loss-of-lock rules.
- Arithmetic is unsigned. X_W/Y_W must hold H_TOTAL-1 and V_TOTAL-1; this is checked by an elaboration assertion.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the default 640x480@60 constants (H_ACTIVE...V_BP);
  - H_TOTAL/V_TOTAL derivation;
  - the sync-window bound constants.
- Sub-module sync_2ff (1-bit, async clear) for the pll_locked synchronizer; it is reused by other PLL-lock consumers.
- The counters, fetch stage and delay pipeline stay in vga_timing_gen.

Test Plan:
- Reset/lock gating: rst=1 then released with pll_locked=0 for 100 cycles -> running=0, de=0, hsync=1, vsync=1 throughout.
- Start-up alignment: raise pll_locked -> running=1 two edges later. Then the next edge gives fetch_valid=1, frame_start=1, fetch_x=0, fetch_y=0. de=1 with x=0, y=0 follows exactly LOOKAHEAD=2 edges later.
- Line timing, one full line:
  - de high for exactly 640 consecutive cycles;
  - hsync low for exactly 96 cycles, starting 16 cycles after de falls;
  - line period 800 cycles;
  - line_start pulses 480 times per frame.
- Frame timing: vsync low for exactly 1600 cycles (2 lines) starting at display line 490. frame_start period is 420000 cycles.
- Mid-line loss of lock: drop pll_locked at display x=300, y=100 -> within 3 edges de=0, hsync=1, vsync=1 and running=0. After relock, the first fetch is (0,0) with frame_start=1.
- Reduced parameters (H 8/2/2/2, V 4/1/1/1, HS_POL=1, LOOKAHEAD=1): hsync high for cycles 10..11 of each 14-cycle line, de leads by exactly 1 cycle, frame = 98 cycles.
